// File: rtl/mipsfpga_ahb_millis_timer_if.sv
// AHB-Lite slave-side bus bundle for the millisecond timer.
// master: drives select/address/control/write data, receives read data and ready.
// slave : the timer side.
interface mipsfpga_ahb_millis_timer_if #(
   parameter int unsigned ADDR_W = 5
);
   logic              HSEL;
   logic [ADDR_W-1:0] HADDR;
   logic [1:0]        HTRANS;
   logic              HWRITE;
   logic              HREADY;
   logic [31:0]       HWDATA;
   logic [31:0]       HRDATA;
   logic              HREADYOUT;

   modport master (
      output HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
      input  HRDATA, HREADYOUT
   );

   modport slave (
      input  HSEL, HADDR, HTRANS, HWRITE, HREADY, HWDATA,
      output HRDATA, HREADYOUT
   );
endinterface

// File: rtl/mipsfpga_ahb_millis_timer.sv
// AHB-Lite millisecond timer peripheral.
// Exposes the free-running millisecond count, a compare/alarm with optional
// periodic auto-reload, and a registered level interrupt on match.
// Ports:
//   clk    - bus clock, shared with the millisecond counter
//   reset  - synchronous, active-high
//   millis - current millisecond count
//   bus    - AHB-Lite slave bundle (HSEL/HADDR/HTRANS/HWRITE/HREADY/HWDATA in,
//            HRDATA/HREADYOUT out)
//   irq    - level interrupt, MATCH & IRQEN
// Register map (word offsets): 0 MILLIS (ro), 1 COMPARE, 2 PERIOD,
// 3 CTRL {AUTORELOAD, IRQEN, EN}, 4 STATUS {OVERRUN, MATCH} (W1C), 5-7 read 0.
module mipsfpga_ahb_millis_timer #(
   parameter int unsigned ADDR_W = 5
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [31:0]                       millis,
   mipsfpga_ahb_millis_timer_if.slave        bus,
   output logic                              irq
);

   localparam logic [2:0] RegMillis  = 3'd0;
   localparam logic [2:0] RegCompare = 3'd1;
   localparam logic [2:0] RegPeriod  = 3'd2;
   localparam logic [2:0] RegCtrl    = 3'd3;
   localparam logic [2:0] RegStatus  = 3'd4;

   logic [ADDR_W-1:0] haddr;
   assign haddr = bus.HADDR;

   // Address-phase registers
   logic       valid_q;
   logic       write_q;
   logic [2:0] addr_q;

   logic [31:0] millis_q;
   logic [31:0] compare_q, compare_d;
   logic [31:0] period_q,  period_d;
   logic [2:0]  ctrl_q,    ctrl_d;
   logic [1:0]  status_q,  status_d;
   logic        irq_q,     irq_d;

   logic        wr_en;
   logic        tick;
   logic        match;
   logic [1:0]  w1c;
   logic [1:0]  status_set;
   logic [31:0] rdata;

   assign wr_en = valid_q & write_q;
   assign tick  = (millis != millis_q);
   assign match = tick & ctrl_q[0] & (millis == compare_q);

   always_comb begin
      compare_d  = compare_q;
      period_d   = period_q;
      ctrl_d     = ctrl_q;
      w1c        = 2'b00;
      status_set = 2'b00;

      if (match) begin
         // A repeat match while MATCH is still pending flags an overrun
         status_set = {status_q[0], 1'b1};
         if (ctrl_q[2]) begin
            compare_d = compare_q + period_q;
         end
      end

      // Software writes are applied after the reload so they take priority
      if (wr_en) begin
         case (addr_q)
            RegCompare: compare_d = bus.HWDATA;
            RegPeriod:  period_d  = bus.HWDATA;
            RegCtrl:    ctrl_d    = bus.HWDATA[2:0];
            RegStatus:  w1c       = bus.HWDATA[1:0];
            default:    ;
         endcase
      end

      // Setting wins over clearing
      status_d = (status_q & ~w1c) | status_set;
      irq_d    = status_d[0] & ctrl_d[1];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         valid_q   <= 1'b0;
         write_q   <= 1'b0;
         addr_q    <= 3'd0;
         millis_q  <= millis;
         compare_q <= 32'hFFFF_FFFF;
         period_q  <= 32'd0;
         ctrl_q    <= 3'd0;
         status_q  <= 2'd0;
         irq_q     <= 1'b0;
      end else begin
         valid_q   <= bus.HSEL & bus.HTRANS[1] & bus.HREADY;
         write_q   <= bus.HWRITE;
         addr_q    <= haddr[4:2];
         millis_q  <= millis;
         compare_q <= compare_d;
         period_q  <= period_d;
         ctrl_q    <= ctrl_d;
         status_q  <= status_d;
         irq_q     <= irq_d;
      end
   end

   always_comb begin
      rdata = 32'd0;
      if (valid_q && !write_q) begin
         case (addr_q)
            RegMillis:  rdata = millis;
            RegCompare: rdata = compare_q;
            RegPeriod:  rdata = period_q;
            RegCtrl:    rdata = {29'd0, ctrl_q};
            RegStatus:  rdata = {30'd0, status_q};
            default:    rdata = 32'd0;
         endcase
      end
   end

   assign bus.HRDATA    = rdata;
   assign bus.HREADYOUT = 1'b1;
   assign irq           = irq_q;

   // Address byte-lane bits, upper address bits and HTRANS[0] are not decoded
   logic unused_bits;
   assign unused_bits = ^{haddr, bus.HTRANS[0]};

endmodule

// File: doc/mipsfpga_ahb_millis_timer.md
# mipsfpga_ahb_millis_timer

AHB-Lite slave peripheral that consumes the free-running 32-bit millisecond count from the millisecond counter and makes it visible to the MIPSfpga core. It returns the count on read and provides a compare/alarm with optional periodic auto-reload. It raises a level interrupt on match. It sits on the AHB bus decoder as one slave, with `millis` wired directly from the counter.

## Interface
- `ADDR_W`, default 5: number of HADDR bits decoded. Register select is HADDR[4:2]; the remaining bits are ignored.
- `clk` input, 1 bit: system/AHB clock, same clock as the millisecond counter.
- `reset` input, 1 bit: synchronous, active-high reset.
- `millis` input, 32 bits: current millisecond count from the counter.
- `HSEL` input, 1 bit: slave select.
- `HADDR` input, `ADDR_W` bits: byte address.
- `HTRANS` input, 2 bits: transfer type. Only bit 1 is used (NONSEQ/SEQ).
- `HWRITE` input, 1 bit: 1 = write.
- `HREADY` input, 1 bit: bus ready. The address phase is accepted only when this is 1.
- `HWDATA` input, 32 bits: write data, valid in the data phase.
- `HRDATA` output, 32 bits: read data, valid in the data phase.
- `HREADYOUT` output, 1 bit: tied to 1. The block never inserts wait states.
- `irq` output, 1 bit: interrupt, registered, level-sensitive.

## Operation
- Register map (word offsets):
  - 0x00 MILLIS, read-only: the current `millis` value.
  - 0x04 COMPARE, read/write: alarm value.
  - 0x08 PERIOD, read/write: auto-reload increment.
  - 0x0C CTRL, read/write: bit0 EN, bit1 IRQEN, bit2 AUTORELOAD. Bits 31:3 read as 0.
  - 0x10 STATUS: bit0 MATCH, bit1 OVERRUN. Writing 1 to a bit clears it. Bits 31:2 read as 0.
- Offsets 0x14–0x1C read as 0. Writes to them, and writes to MILLIS, are ignored.
- Tick detect: `millis_q` holds the previous `millis`. A tick is the condition `millis != millis_q`.
- Match: a match occurs when there is a tick, EN=1, and `millis == COMPARE`. On a match:
  - MATCH is set to 1.
  - If MATCH was already 1, OVERRUN is also set to 1.
  - If AUTORELOAD=1, COMPARE is loaded with COMPARE + PERIOD, modulo 2^32. Wrap-around is silent.
- No tick means no match, even if COMPARE is written equal to the current `millis`.
- `irq` is loaded each cycle with MATCH_next & IRQEN.

## Timing
- Reset (synchronous, on the clock edge while `reset`=1):
  - COMPARE = 0xFFFFFFFF, PERIOD = 0, CTRL = 0, STATUS = 0, `irq` = 0.
  - `millis_q` is loaded with `millis`, so no false tick occurs after reset.
  - The registered address-phase signals are cleared, so no write is pending.
  - Any transfer in flight is dropped.
- Address phase in cycle N: HSEL, HADDR, HWRITE and "valid" (HSEL & HTRANS[1] & HREADY) are registered at the end of cycle N.
- Write: HWDATA is sampled in cycle N+1. The register updates at the end of cycle N+1. A read whose data phase is in N+2 (back-to-back) returns the new value.
- Read: HRDATA is combinational from the registered address and the current register contents during cycle N+1. HRDATA = 0 when no read is in its data phase.
- MILLIS read returns `millis` as present in the data-phase cycle.
- Match latency: if `millis` first shows the matching value in cycle M, then MATCH=1 and the reloaded COMPARE are visible from cycle M+1, and `irq` is 1 from cycle M+1.
- Simultaneous events resolved in the same cycle:
  - A software write to COMPARE beats the auto-reload update.
  - A STATUS W1C of MATCH loses to a new match, so MATCH stays 1.
  - W1C of MATCH with no new match: MATCH=0 and `irq`=0 from the next cycle.
  - Clearing IRQEN drops `irq` in the next cycle; MATCH is preserved.
- HREADY=0 in an address phase: the transfer is not accepted and no register changes.

## Test plan
- Reset, then read every offset: MILLIS = `millis`, COMPARE = 0xFFFFFFFF, PERIOD = 0, CTRL = 0, STATUS = 0, 0x14 = 0; `irq` = 0.
- Write COMPARE=5, CTRL=0x3, drive `millis` 3→4→5: MATCH=1 and `irq`=1 exactly one cycle after `millis` reaches 5. Write 0x1 to STATUS: `irq`=0 in the following cycle.
- Auto-reload: COMPARE=0xFFFFFFFE, PERIOD=3, CTRL=0x7, step `millis` to 0xFFFFFFFE: COMPARE becomes 0x00000001 (wrap). Step `millis` to 1: second match; with MATCH left uncleared, OVERRUN=1.
- Back-to-back write COMPARE=0x10 then read COMPARE: read returns 0x10. Drive a COMPARE write in the same cycle as a reload: the written value persists.
- Write COMPARE equal to the static `millis`=7 with EN=1 and no tick: MATCH stays 0. Pulse `reset` mid-transfer: all registers return to reset values and no false match occurs after reset.
- HSEL=1 and HWRITE=1 with HREADY=0 or HTRANS=IDLE: no register changes. A write to MILLIS is ignored.
